// File: rtl/execute_stage_mdu_if.sv
// Execute-stage bundle: ID/EX controls and operands in, E/M register and fetch redirect out.
// master = decode/hazard side driving the stage, slave = the execute stage itself.
interface execute_stage_mdu_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              FlushE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic [1:0]        ResultSrcE;
    logic              BranchE;
    logic              JumpE;
    logic              ALUSrcE;
    logic [3:0]        ALUControlE;
    logic [2:0]        Funct3E;
    logic              MdValidE;
    logic [1:0]        MdOpE;
    logic [XLEN-1:0]   RD1_E;
    logic [XLEN-1:0]   RD2_E;
    logic [XLEN-1:0]   Imm_Ext_E;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [REG_AW-1:0] RD_E;
    logic [XLEN-1:0]   ResultW;
    logic [1:0]        ForwardA_E;
    logic [1:0]        ForwardB_E;

    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic              StallE;
    logic              RegWriteM;
    logic              MemWriteM;
    logic [1:0]        ResultSrcM;
    logic [REG_AW-1:0] RD_M;
    logic [XLEN-1:0]   PCPlus4M;
    logic [XLEN-1:0]   WriteDataM;
    logic [XLEN-1:0]   ALU_ResultM;

    modport master (
        output FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE,
               ALUControlE, Funct3E, MdValidE, MdOpE, RD1_E, RD2_E, Imm_Ext_E,
               PCE, PCPlus4E, RD_E, ResultW, ForwardA_E, ForwardB_E,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport slave (
        input  FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE,
               ALUControlE, Funct3E, MdValidE, MdOpE, RD1_E, RD2_E, Imm_Ext_E,
               PCE, PCPlus4E, RD_E, ResultW, ForwardA_E, ForwardB_E,
        output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_stage_mdu.sv
// RISC-V execute stage: forwarding, ALU, branch resolve, E/M register and an optional
// iterative multiply/divide unit built only when EXEC_MDU_EN is defined.
//
// state | meaning
// IDLE  | no MDU op in flight; accepts MdValidE and latches operand magnitudes
// BUSY  | one radix-2 multiply or restoring-divide step per cycle, pipeline stalled
// DONE  | sign-corrected result handed to the E/M register, stall released
module execute_stage_mdu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic               clk,
    input logic               rst,
    execute_stage_mdu_if.slave ex
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic            br_cond;

    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_res;

    always_comb begin
        case (ex.ForwardA_E)
            2'b01:   src_a = ex.ResultW;
            2'b10:   src_a = ex.ALU_ResultM;
            default: src_a = ex.RD1_E;
        endcase
        case (ex.ForwardB_E)
            2'b01:   src_b_fwd = ex.ResultW;
            2'b10:   src_b_fwd = ex.ALU_ResultM;
            default: src_b_fwd = ex.RD2_E;
        endcase
    end

    assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : src_b_fwd;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (ex.ALUControlE)
            4'd0:    alu_res = src_a + src_b;
            4'd1:    alu_res = src_a - src_b;
            4'd2:    alu_res = src_a & src_b;
            4'd3:    alu_res = src_a | src_b;
            4'd4:    alu_res = src_a ^ src_b;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'd7:    alu_res = src_a << shamt;
            4'd8:    alu_res = src_a >> shamt;
            4'd9:    alu_res = $signed(src_a) >>> shamt;
            4'd10:   alu_res = src_b;
            default: alu_res = '0;
        endcase
    end

    // Branch compares always use the register operands, never the immediate.
    always_comb begin
        br_cond = 1'b0;
        case (ex.Funct3E)
            3'b000:  br_cond = (src_a == src_b_fwd);
            3'b001:  br_cond = (src_a != src_b_fwd);
            3'b100:  br_cond = ($signed(src_a) <  $signed(src_b_fwd));
            3'b101:  br_cond = ($signed(src_a) >= $signed(src_b_fwd));
            3'b110:  br_cond = (src_a <  src_b_fwd);
            3'b111:  br_cond = (src_a >= src_b_fwd);
            default: br_cond = 1'b0;
        endcase
    end

    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;
    assign ex.PCSrcE    = (ex.JumpE | (ex.BranchE & br_cond)) & ~md_busy & ~ex.FlushE;
    assign ex.StallE    = md_busy;

`ifdef EXEC_MDU_EN
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mq_q, mq_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            dz_q, dz_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic [2*XLEN-1:0] prod, prod_s;

    assign a_neg = src_a[XLEN-1];
    assign b_neg = src_b_fwd[XLEN-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b_fwd : src_b_fwd;

    // {acc, mq} holds the partial product (multiply) or remainder/quotient (divide).
    assign mul_sum  = {1'b0, acc_q} + {1'b0, dvs_q & {XLEN{mq_q[0]}}};
    assign rem_sh   = {acc_q, mq_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};

    assign prod   = {acc_q, mq_q};
    assign prod_s = neg_q ? -prod : prod;

    always_comb begin
        case (op_q)
            2'b00:   md_res = prod_s[XLEN-1:0];
            2'b01:   md_res = prod_s[2*XLEN-1:XLEN];
            2'b10:   md_res = dz_q ? '1 : (neg_q ? -mq_q : mq_q);
            default: md_res = neg_q ? -acc_q : acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        md_busy = 1'b0;
        md_done = 1'b0;
        if (ex.FlushE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ex.MdValidE) begin
                        md_busy = 1'b1;
                        acc_d   = '0;
                        mq_d    = a_mag;
                        dvs_d   = b_mag;
                        cnt_d   = CW'(XLEN);
                        op_d    = ex.MdOpE;
                        // Remainder takes the dividend's sign; everything else the product sign.
                        neg_d   = (ex.MdOpE == 2'b11) ? a_neg : (a_neg ^ b_neg);
                        dz_d    = (src_b_fwd == '0);
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    md_busy = 1'b1;
                    if (op_q[1]) begin
                        if (!rem_diff[XLEN]) begin
                            acc_d = rem_diff[XLEN-1:0];
                            mq_d  = {mq_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = rem_sh[XLEN-1:0];
                            mq_d  = {mq_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        mq_d  = {mul_sum[0], mq_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    md_done = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
        end
    end
`else
    logic unused_md;

    assign unused_md = ex.MdValidE ^ ex.MdOpE[0] ^ ex.MdOpE[1];
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_res    = '0;
`endif

    logic              m_regwrite_q, m_regwrite_d;
    logic              m_memwrite_q, m_memwrite_d;
    logic [1:0]        m_resultsrc_q, m_resultsrc_d;
    logic [REG_AW-1:0] m_rd_q, m_rd_d;
    logic [XLEN-1:0]   m_pcplus4_q, m_pcplus4_d;
    logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
    logic [XLEN-1:0]   m_alures_q, m_alures_d;

    // Flush and stall both push a bubble; the MDU result wins over the ALU only in DONE.
    always_comb begin
        m_regwrite_d  = 1'b0;
        m_memwrite_d  = 1'b0;
        m_resultsrc_d = '0;
        m_rd_d        = '0;
        m_pcplus4_d   = '0;
        m_wdata_d     = '0;
        m_alures_d    = '0;
        if (!ex.FlushE && !md_busy) begin
            m_regwrite_d  = ex.RegWriteE;
            m_memwrite_d  = ex.MemWriteE;
            m_resultsrc_d = ex.ResultSrcE;
            m_rd_d        = ex.RD_E;
            m_pcplus4_d   = ex.PCPlus4E;
            m_wdata_d     = src_b_fwd;
            m_alures_d    = md_done ? md_res : alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_regwrite_q  <= 1'b0;
            m_memwrite_q  <= 1'b0;
            m_resultsrc_q <= '0;
            m_rd_q        <= '0;
            m_pcplus4_q   <= '0;
            m_wdata_q     <= '0;
            m_alures_q    <= '0;
        end else begin
            m_regwrite_q  <= m_regwrite_d;
            m_memwrite_q  <= m_memwrite_d;
            m_resultsrc_q <= m_resultsrc_d;
            m_rd_q        <= m_rd_d;
            m_pcplus4_q   <= m_pcplus4_d;
            m_wdata_q     <= m_wdata_d;
            m_alures_q    <= m_alures_d;
        end
    end

    assign ex.RegWriteM   = m_regwrite_q;
    assign ex.MemWriteM   = m_memwrite_q;
    assign ex.ResultSrcM  = m_resultsrc_q;
    assign ex.RD_M        = m_rd_q;
    assign ex.PCPlus4M    = m_pcplus4_q;
    assign ex.WriteDataM  = m_wdata_q;
    assign ex.ALU_ResultM = m_alures_q;
endmodule

// File: tb/tb_execute_stage_mdu.sv
// Directed bench for execute_stage_mdu; MDU vectors are exercised when EXEC_MDU_EN is defined,
// otherwise MD instructions are checked to fall through to the ALU.
module tb_execute_stage_mdu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    execute_stage_mdu_if #(.XLEN(32), .REG_AW(5)) bus ();

    execute_stage_mdu #(.XLEN(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.FlushE      = 1'b0;
        bus.RegWriteE   = 1'b0;
        bus.MemWriteE   = 1'b0;
        bus.ResultSrcE  = 2'b00;
        bus.BranchE     = 1'b0;
        bus.JumpE       = 1'b0;
        bus.ALUSrcE     = 1'b0;
        bus.ALUControlE = 4'd0;
        bus.Funct3E     = 3'b010;
        bus.MdValidE    = 1'b0;
        bus.MdOpE       = 2'b00;
        bus.RD1_E       = '0;
        bus.RD2_E       = '0;
        bus.Imm_Ext_E   = '0;
        bus.PCE         = '0;
        bus.PCPlus4E    = '0;
        bus.RD_E        = '0;
        bus.ResultW     = '0;
        bus.ForwardA_E  = 2'b00;
        bus.ForwardB_E  = 2'b00;
    endtask

    task automatic alu_vec(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                           input logic use_imm, input logic [31:0] exp, input string tag);
        idle_in();
        bus.ALUControlE = ctrl;
        bus.RD1_E       = a;
        bus.ALUSrcE     = use_imm;
        bus.Imm_Ext_E   = b;
        bus.RD2_E       = use_imm ? 32'hDEAD_0000 : b;
        bus.RegWriteE   = 1'b1;
        bus.RD_E        = 5'd3;
        step();
        chk(tag, bus.ALU_ResultM, exp);
    endtask

`ifdef EXEC_MDU_EN
    task automatic md_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int stalls;
        int writes;
        int redirects;
        idle_in();
        bus.RD1_E       = a;
        bus.RD2_E       = b;
        bus.MdValidE    = 1'b1;
        bus.MdOpE       = op;
        bus.RegWriteE   = 1'b1;
        bus.RD_E        = 5'd9;
        bus.JumpE       = 1'b1;
        stalls    = 0;
        writes    = 0;
        redirects = 0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (!bus.StallE) break;
            stalls++;
            if (bus.PCSrcE) redirects++;
            @(posedge clk);
            #1;
            if (bus.RegWriteM) writes++;
        end
        chk({tag, " stall cycles"}, stalls, 33);
        chk({tag, " M write during stall"}, writes, 0);
        chk({tag, " redirect during stall"}, redirects, 0);
        step();
        chk({tag, " result"}, bus.ALU_ResultM, exp);
        chk({tag, " RegWriteM"}, bus.RegWriteM, 1);
        chk({tag, " RD_M"}, bus.RD_M, 9);
        idle_in();
    endtask
`endif

    initial begin
        idle_in();
        bus.RegWriteE = 1'b1;
        bus.MemWriteE = 1'b1;
        bus.RD1_E     = 32'h55;
        bus.RD2_E     = 32'h66;
        bus.RD_E      = 5'd3;
        bus.PCPlus4E  = 32'h44;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset RegWriteM", bus.RegWriteM, 0);
        chk("reset MemWriteM", bus.MemWriteM, 0);
        chk("reset ALU_ResultM", bus.ALU_ResultM, 0);
        chk("reset RD_M", bus.RD_M, 0);
        chk("reset PCPlus4M", bus.PCPlus4M, 0);
        chk("reset WriteDataM", bus.WriteDataM, 0);
        chk("reset StallE", bus.StallE, 0);
        chk("reset PCSrcE", bus.PCSrcE, 0);
        rst = 1'b0;
        idle_in();
        step();

        // Forwarding
        bus.RD1_E      = 32'h10;
        bus.ForwardA_E = 2'b01;
        bus.ResultW    = 32'h30;
        bus.RD2_E      = 32'h20;
        bus.RegWriteE  = 1'b1;
        bus.MemWriteE  = 1'b1;
        bus.ResultSrcE = 2'b10;
        bus.RD_E       = 5'd5;
        bus.PCPlus4E   = 32'h104;
        step();
        chk("fwd A=ResultW sum", bus.ALU_ResultM, 32'h50);
        chk("fwd RD_M", bus.RD_M, 5);
        chk("fwd RegWriteM", bus.RegWriteM, 1);
        chk("fwd MemWriteM", bus.MemWriteM, 1);
        chk("fwd ResultSrcM", bus.ResultSrcM, 2);
        chk("fwd PCPlus4M", bus.PCPlus4M, 32'h104);
        chk("fwd WriteDataM", bus.WriteDataM, 32'h20);
        bus.ForwardB_E = 2'b10;
        step();
        chk("fwd B=ALU_ResultM sum", bus.ALU_ResultM, 32'h80);
        chk("fwd WriteDataM from M", bus.WriteDataM, 32'h50);

        // ALU ops
        alu_vec(4'd1,  32'h10,        32'h20,       1'b0, 32'hFFFF_FFF0, "SUB");
        alu_vec(4'd2,  32'hF0F0,      32'hFF00,     1'b0, 32'hF000,      "AND");
        alu_vec(4'd3,  32'hF0F0,      32'h0F00,     1'b0, 32'hFFF0,      "OR");
        alu_vec(4'd4,  32'hFF,        32'h0F,       1'b0, 32'hF0,        "XOR");
        alu_vec(4'd5,  32'hFFFF_FFFF, 32'h1,        1'b0, 32'h1,         "SLT");
        alu_vec(4'd6,  32'hFFFF_FFFF, 32'h1,        1'b0, 32'h0,         "SLTU");
        alu_vec(4'd7,  32'h1,         32'h24,       1'b0, 32'h10,        "SLL");
        alu_vec(4'd8,  32'h8000_0000, 32'h24,       1'b0, 32'h0800_0000, "SRL");
        alu_vec(4'd9,  32'h8000_0000, 32'h24,       1'b0, 32'hF800_0000, "SRA");
        alu_vec(4'd10, 32'h5,         32'h1234,     1'b1, 32'h1234,      "PASSB imm");
        alu_vec(4'd0,  32'hFFFF_FFFF, 32'h2,        1'b1, 32'h1,         "ADD wrap imm");
        alu_vec(4'd12, 32'h5,         32'h6,        1'b0, 32'h0,         "ctrl 12");

        // Branch resolution (combinational)
        idle_in();
        bus.PCE       = 32'h100;
        bus.Imm_Ext_E = 32'h20;
        bus.RD1_E     = 32'd5;
        bus.RD2_E     = 32'd5;
        bus.BranchE   = 1'b1;
        bus.Funct3E   = 3'b000;
        #1;
        chk("BEQ taken", bus.PCSrcE, 1);
        chk("PCTargetE", bus.PCTargetE, 32'h120);
        bus.Funct3E = 3'b001;
        #1;
        chk("BNE not taken", bus.PCSrcE, 0);
        bus.RD1_E   = 32'hFFFF_FFFF;
        bus.RD2_E   = 32'd1;
        bus.Funct3E = 3'b110;
        #1;
        chk("BLTU not taken", bus.PCSrcE, 0);
        bus.Funct3E = 3'b100;
        #1;
        chk("BLT taken", bus.PCSrcE, 1);
        bus.Funct3E = 3'b111;
        #1;
        chk("BGEU taken", bus.PCSrcE, 1);
        bus.Funct3E = 3'b010;
        #1;
        chk("funct3 010 false", bus.PCSrcE, 0);
        bus.BranchE = 1'b0;
        bus.JumpE   = 1'b1;
        #1;
        chk("JAL redirect", bus.PCSrcE, 1);
        bus.FlushE    = 1'b1;
        bus.RegWriteE = 1'b1;
        bus.RD_E      = 5'd4;
        #1;
        chk("flush kills redirect", bus.PCSrcE, 0);
        step();
        chk("flush bubble RegWriteM", bus.RegWriteM, 0);
        chk("flush bubble RD_M", bus.RD_M, 0);
        idle_in();

`ifdef EXEC_MDU_EN
        md_run(2'b10, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, "DIV -20/3");
        md_run(2'b11, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, "REM -20/3");
        md_run(2'b10, 32'd7,         32'd0,        32'hFFFF_FFFF, "DIV 7/0");
        md_run(2'b11, 32'd7,         32'd0,        32'd7,         "REM 7/0");
        md_run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
        md_run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        "REM ovf");
        md_run(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH minneg^2");
        md_run(2'b00, 32'h8000_0000, 32'h8000_0000, 32'd0,        "MUL minneg^2");
        md_run(2'b00, 32'd6,         32'hFFFF_FFF9, 32'hFFFF_FFD6, "MUL 6*-7");
        md_run(2'b01, 32'd6,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "MULH 6*-7");
        md_run(2'b11, 32'd100,       32'd7,        32'd2,         "REM 100/7");

        // Abort by reset in the middle of BUSY
        idle_in();
        bus.RD1_E     = 32'd100;
        bus.RD2_E     = 32'd7;
        bus.MdValidE  = 1'b1;
        bus.MdOpE     = 2'b10;
        bus.RegWriteE = 1'b1;
        repeat (10) step();
        chk("rst abort busy before", bus.StallE, 1);
        rst          = 1'b1;
        bus.MdValidE = 1'b0;
        step();
        chk("rst abort StallE", bus.StallE, 0);
        chk("rst abort RegWriteM", bus.RegWriteM, 0);
        chk("rst abort ALU_ResultM", bus.ALU_ResultM, 0);
        rst = 1'b0;
        alu_vec(4'd0, 32'd3, 32'd4, 1'b0, 32'd7, "ADD after rst abort");
        chk("ADD after rst abort RegWriteM", bus.RegWriteM, 1);

        // Abort by flush in the middle of BUSY
        idle_in();
        bus.RD1_E     = 32'd100;
        bus.RD2_E     = 32'd7;
        bus.MdValidE  = 1'b1;
        bus.MdOpE     = 2'b10;
        bus.RegWriteE = 1'b1;
        repeat (10) step();
        chk("flush abort busy before", bus.StallE, 1);
        bus.FlushE = 1'b1;
        #1;
        chk("flush drops StallE same cycle", bus.StallE, 0);
        step();
        bus.FlushE   = 1'b0;
        bus.MdValidE = 1'b0;
        #1;
        chk("flush abort StallE", bus.StallE, 0);
        chk("flush abort RegWriteM", bus.RegWriteM, 0);
        alu_vec(4'd0, 32'd3, 32'd4, 1'b0, 32'd7, "ADD after flush abort");
        idle_in();
        begin
            int late_writes;
            late_writes = 0;
            repeat (40) begin
                step();
                if (bus.RegWriteM || bus.StallE) late_writes++;
            end
            chk("no MDU write after flush", late_writes, 0);
        end
`else
        // Without the MDU, an MD instruction is just the ALU op and never stalls.
        idle_in();
        bus.RD1_E       = 32'hFFFF_FFEC;
        bus.RD2_E       = 32'd3;
        bus.MdValidE    = 1'b1;
        bus.MdOpE       = 2'b10;
        bus.ALUControlE = 4'd0;
        bus.RegWriteE   = 1'b1;
        #1;
        chk("no-MDU StallE", bus.StallE, 0);
        step();
        chk("no-MDU ALU result", bus.ALU_ResultM, 32'hFFFF_FFEF);
        chk("no-MDU RegWriteM", bus.RegWriteM, 1);
        idle_in();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
